spi_apb_master: RTL and testbench

APB requester sitting between the SPI frame deserialiser and `secure_fsm`. It takes one decoded command per handshake, runs one APB transfer (setup phase, then access phase) on the `*_s` bus that `secure_fsm` consumes, and waits for `pready_s` under a timeout. It then returns read data and error status to the SPI response serialiser. A saturating error counter supports debug.

---
 rtl/spi_apb_master.sv | 149 ++++++++++++++
 tb/tb_spi_apb_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_master.sv
// spi_apb_master: takes one decoded SPI command, runs a single APB transfer
// toward secure_fsm under an access-phase timeout, and returns read data and
// error status to the SPI response serialiser.
module spi_apb_master #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    // Command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_sel,
    input  logic [1:0]  cmd_strb,
    input  logic [19:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    // APB requester toward secure_fsm
    output logic [1:0]  psel_s,
    output logic        penable_s,
    output logic        pwrite_s,
    output logic [1:0]  pstrb_s,
    output logic [19:0] paddr_s,
    output logic [15:0] pwdata_s,
    input  logic [15:0] prdata_s,
    input  logic        pready_s,
    input  logic        pslverr_s_rm,
    input  logic        pslverr_s_icn,
    // Response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [7:0]  err_count
);

    // Wide enough to hold TIMEOUT-1 for any legal TIMEOUT (2..1024).
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_t;

    state_t          state;
    logic [CntW-1:0] cnt;
    logic [7:0]      err_count_sat;
    logic            sel_legal;
    logic            slv_err;

    // Saturating next value of the error counter and decoded helpers.
    always_comb begin
        err_count_sat = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
        sel_legal     = (cmd_sel == 2'b01) || (cmd_sel == 2'b10);
        slv_err       = pslverr_s_rm | pslverr_s_icn;
    end

    // Transfer sequencer; every output is a register written here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            psel_s    <= 2'b00;
            penable_s <= 1'b0;
            pwrite_s  <= 1'b0;
            pstrb_s   <= 2'b00;
            paddr_s   <= 20'h0;
            pwdata_s  <= 16'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0;
            rsp_err   <= 2'b00;
            err_count <= 8'h00;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (sel_legal) begin
                            // The bus registers double as the command latch.
                            state    <= StSetup;
                            psel_s   <= cmd_sel;
                            pwrite_s <= cmd_write;
                            pstrb_s  <= cmd_strb;
                            paddr_s  <= cmd_addr;
                            pwdata_s <= cmd_wdata;
                        end else begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 2'b10;
                            rsp_rdata <= 16'h0;
                            err_count <= err_count_sat;
                        end
                    end
                end
                StSetup: begin
                    state     <= StAccess;
                    penable_s <= 1'b1;
                    cnt       <= '0;
                end
                StAccess: begin
                    if (pready_s) begin
                        // Completion wins over a timeout landing on the same cycle.
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= {1'b0, slv_err};
                        rsp_rdata <= (!pwrite_s && !slv_err) ? prdata_s : 16'h0;
                        if (slv_err) begin
                            err_count <= err_count_sat;
                        end
                        psel_s    <= 2'b00;
                        penable_s <= 1'b0;
                        pwrite_s  <= 1'b0;
                        pstrb_s   <= 2'b00;
                        paddr_s   <= 20'h0;
                        pwdata_s  <= 16'h0;
                    end else if (cnt == CntW'(TIMEOUT - 1)) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 2'b10;
                        rsp_rdata <= 16'h0;
                        err_count <= err_count_sat;
                        psel_s    <= 2'b00;
                        penable_s <= 1'b0;
                        pwrite_s  <= 1'b0;
                        pstrb_s   <= 2'b00;
                        paddr_s   <= 20'h0;
                        pwdata_s  <= 16'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 2'b00;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_apb_master.sv
// Self-checking bench for spi_apb_master: directed cases followed by random
// commands, each checked against a transaction-level expectation.
module tb_spi_apb_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_sel;
    logic [1:0]  cmd_strb;
    logic [19:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  psel_s;
    logic        penable_s;
    logic        pwrite_s;
    logic [1:0]  pstrb_s;
    logic [19:0] paddr_s;
    logic [15:0] pwdata_s;
    logic [15:0] prdata_s;
    logic        pready_s;
    logic        pslverr_s_rm;
    logic        pslverr_s_icn;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    spi_apb_master #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_sel       (cmd_sel),
        .cmd_strb      (cmd_strb),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .psel_s        (psel_s),
        .penable_s     (penable_s),
        .pwrite_s      (pwrite_s),
        .pstrb_s       (pstrb_s),
        .paddr_s       (paddr_s),
        .pwdata_s      (pwdata_s),
        .prdata_s      (prdata_s),
        .pready_s      (pready_s),
        .pslverr_s_rm  (pslverr_s_rm),
        .pslverr_s_icn (pslverr_s_icn),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
        chk({tag, "_psel"},      32'(psel_s),    32'd0);
        chk({tag, "_penable"},   32'(penable_s), 32'd0);
        chk({tag, "_pwrite"},    32'(pwrite_s),  32'd0);
        chk({tag, "_pstrb"},     32'(pstrb_s),   32'd0);
        chk({tag, "_paddr"},     32'(paddr_s),   32'd0);
        chk({tag, "_pwdata"},    32'(pwdata_s),  32'd0);
    endtask

    // One command end to end. ready_at = ACCESS cycle (1-based) in which pready
    // is high; anything outside 1..TMO means pready never comes.
    task automatic run_cmd(input logic wr, input logic [1:0] sel, input logic [1:0] strb,
                           input logic [19:0] addr, input logic [15:0] wd, input int ready_at,
                           input logic e_rm, input logic e_icn, input logic [15:0] rd);
        bit          legal;
        bit          done;
        int          k;
        int          exp_cycles;
        int          hold;
        logic [1:0]  e_err;
        logic [15:0] e_rdata;

        // Expected outcome from the command-level rules.
        legal = (sel == 2'b01) || (sel == 2'b10);
        if (!legal) begin
            exp_cycles = 0;
            e_err      = 2'b10;
            e_rdata    = 16'h0;
        end else if (ready_at >= 1 && ready_at <= TMO) begin
            exp_cycles = ready_at;
            e_err      = {1'b0, e_rm | e_icn};
            e_rdata    = (wr || (e_rm | e_icn)) ? 16'h0 : rd;
        end else begin
            exp_cycles = TMO;
            e_err      = 2'b10;
            e_rdata    = 16'h0;
        end
        if (e_err != 2'b00 && exp_cnt < 255) exp_cnt++;

        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_sel   = sel;
        cmd_strb  = strb;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs so the DUT must rely on its latched copy.
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_sel   = 2'($urandom);
        cmd_strb  = 2'($urandom);
        cmd_addr  = 20'($urandom);
        cmd_wdata = 16'($urandom);

        if (legal) begin
            chk("setup_psel",    32'(psel_s),    32'(sel));
            chk("setup_penable", 32'(penable_s), 32'd0);
            chk("setup_pwrite",  32'(pwrite_s),  32'(wr));
            chk("setup_pstrb",   32'(pstrb_s),   32'(strb));
            chk("setup_paddr",   32'(paddr_s),   32'(addr));
            chk("setup_pwdata",  32'(pwdata_s),  32'(wd));
            chk("setup_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
            // pready/pslverr during SETUP must be ignored.
            pready_s      = 1'b1;
            pslverr_s_rm  = 1'b1;
            pslverr_s_icn = 1'b1;
            prdata_s      = 16'($urandom);
            k    = 0;
            done = 0;
            while (!done && k < 2 * TMO + 4) begin
                @(negedge clk);
                if (rsp_valid === 1'b1) begin
                    done = 1;
                end else begin
                    k++;
                    chk("access_psel",    32'(psel_s),    32'(sel));
                    chk("access_penable", 32'(penable_s), 32'd1);
                    chk("access_paddr",   32'(paddr_s),   32'(addr));
                    chk("access_pwdata",  32'(pwdata_s),  32'(wd));
                    pready_s      = (k == ready_at);
                    pslverr_s_rm  = e_rm;
                    pslverr_s_icn = e_icn;
                    prdata_s      = (k == ready_at) ? rd : 16'($urandom);
                end
            end
            chk("access_cycles", 32'(k), 32'(exp_cycles));
        end

        chk("resp_valid",     32'(rsp_valid), 32'd1);
        chk("resp_err",       32'(rsp_err),   32'(e_err));
        chk("resp_rdata",     32'(rsp_rdata), 32'(e_rdata));
        chk("resp_err_count", 32'(err_count), 32'(exp_cnt));
        chk("resp_psel",      32'(psel_s),    32'd0);
        chk("resp_penable",   32'(penable_s), 32'd0);
        chk("resp_paddr",     32'(paddr_s),   32'd0);
        chk("resp_pwdata",    32'(pwdata_s),  32'd0);
        chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);

        // Response must hold while rsp_ready is low, regardless of bus noise.
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            pready_s      = 1'($urandom);
            pslverr_s_rm  = 1'($urandom);
            pslverr_s_icn = 1'($urandom);
            prdata_s      = 16'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_err",   32'(rsp_err),   32'(e_err));
            chk("hold_rdata", 32'(rsp_rdata), 32'(e_rdata));
            chk("hold_count", 32'(err_count), 32'(exp_cnt));
        end

        rsp_ready     = 1'b1;
        pready_s      = 1'b0;
        pslverr_s_rm  = 1'b0;
        pslverr_s_icn = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_valid",     32'(rsp_valid), 32'd0);
        chk("done_err",       32'(rsp_err),   32'd0);
        chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("done_psel",      32'(psel_s),    32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_write     = 1'b0;
        cmd_sel       = 2'b00;
        cmd_strb      = 2'b00;
        cmd_addr      = 20'h0;
        cmd_wdata     = 16'h0;
        prdata_s      = 16'h0;
        pready_s      = 1'b0;
        pslverr_s_rm  = 1'b0;
        pslverr_s_icn = 1'b0;
        rsp_ready     = 1'b0;
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("post_reset");

        // RM read, ready in 2nd ACCESS cycle.
        run_cmd(1'b0, 2'b01, 2'b11, 20'h00010, 16'h5555, 2, 1'b0, 1'b0, 16'h1234);
        // Locked ICN write.
        run_cmd(1'b1, 2'b10, 2'b11, 20'h00200, 16'h00FF, 1, 1'b0, 1'b1, 16'hBEEF);
        chk("locked_err_count", 32'(err_count), 32'd1);
        // Unlock write.
        run_cmd(1'b1, 2'b10, 2'b11, 20'h00C1A, 16'hA007, 1, 1'b0, 1'b0, 16'h0000);
        // Timeout, then completion on the timeout cycle.
        run_cmd(1'b0, 2'b01, 2'b01, 20'h00ABC, 16'h0001, 0, 1'b0, 1'b0, 16'h7777);
        run_cmd(1'b0, 2'b01, 2'b10, 20'h00ABD, 16'h0002, TMO, 1'b0, 1'b0, 16'h7778);
        // RM slave error on a read clears rdata.
        run_cmd(1'b0, 2'b01, 2'b11, 20'h00044, 16'h0003, 3, 1'b1, 1'b0, 16'h9999);
        // Illegal selects.
        run_cmd(1'b0, 2'b11, 2'b11, 20'h00100, 16'h0004, 1, 1'b0, 1'b0, 16'h1111);
        run_cmd(1'b1, 2'b00, 2'b11, 20'h00101, 16'h0005, 1, 1'b0, 1'b0, 16'h2222);

        // Random commands.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] s;
            s = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1) * 3) :
                2'($urandom_range(1, 2));
            run_cmd(1'($urandom), s, 2'($urandom), 20'($urandom), 16'($urandom),
                    $urandom_range(0, TMO + 1), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) == 0), 16'($urandom));
        end

        // Saturation via illegal selects.
        for (int i = 0; i < 300; i++) begin
            run_cmd(1'b0, 2'b11, 2'b00, 20'h0, 16'h0, 1, 1'b0, 1'b0, 16'h0);
        end
        chk("saturated_count", 32'(err_count), 32'd255);

        // Reset during ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_sel   = 2'b01;
        cmd_strb  = 2'b11;
        cmd_addr  = 20'h00321;
        cmd_wdata = 16'h4321;
        pready_s  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_penable", 32'(penable_s), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("mid_reset");
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("after_reset_valid", 32'(rsp_valid), 32'd0);
        chk("after_reset_ready", 32'(cmd_ready), 32'd1);
        run_cmd(1'b0, 2'b10, 2'b11, 20'h00555, 16'h0006, 2, 1'b0, 1'b0, 16'hCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
